// File: rtl/sys_print_arb.sv
// Print-string syscall engine. It takes over the CPU data-memory port, walks a
// null-terminated byte string word by word, and streams its characters to a sink.
module sys_print_arb #(
  parameter int unsigned MAX_WORDS = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sys,
  input  logic [31:0] regv,
  input  logic [31:0] rega,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_memwrite,
  input  logic        cpu_memwrite8,
  output logic [31:0] cpu_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_memwrite,
  output logic        mem_memwrite8,
  input  logic [31:0] mem_rdata,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        cpu_stall,
  output logic        sys_done,
  output logic        sys_err
);

  localparam int unsigned WW = $clog2(MAX_WORDS) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state_r;
  logic [31:0]    ptr_r;
  logic [31:0]    word_r;
  logic [WW-1:0]  wcnt_r;
  logic [1:0]     bidx_r;
  logic           err_r;

  logic [7:0]     byte_s;
  logic           engine_s;
  logic           advance_s;
  logic [WW-1:0]  wcnt_inc_s;

  // Select the current byte of the fetched word, low byte first
  always_comb begin
    byte_s = 8'd0;
    case (bidx_r)
      2'd0:    byte_s = word_r[7:0];
      2'd1:    byte_s = word_r[15:8];
      2'd2:    byte_s = word_r[23:16];
      2'd3:    byte_s = word_r[31:24];
      default: byte_s = 8'd0;
    endcase
  end

  // Gated by rst_n so the CPU keeps the port even before reset has been sampled
  assign engine_s   = rst_n && (state_r != IDLE);
  assign advance_s  = (byte_s == 8'd0) || char_ready;
  assign wcnt_inc_s = wcnt_r + WW'(1);

  // Memory port arbitration: CPU pass-through in IDLE, engine read-only otherwise
  always_comb begin
    if (engine_s) begin
      mem_addr      = ptr_r;
      mem_wdata     = cpu_wdata;
      mem_memwrite  = 1'b0;
      mem_memwrite8 = 1'b0;
    end else begin
      mem_addr      = cpu_addr;
      mem_wdata     = cpu_wdata;
      mem_memwrite  = cpu_memwrite;
      mem_memwrite8 = cpu_memwrite8;
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign cpu_stall  = engine_s;
  assign char_valid = rst_n && (state_r == EMIT) && (byte_s != 8'd0);
  assign char_data  = byte_s;
  assign sys_done   = rst_n && (state_r == DONE);
  assign sys_err    = sys_done && err_r;

  // Print engine state machine
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= 32'd0;
      wcnt_r  <= '0;
      word_r  <= 32'd0;
      bidx_r  <= 2'd0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (sys) begin
            if (regv == 32'd4) begin
              state_r <= FETCH;
              ptr_r   <= rega;
              wcnt_r  <= '0;
            end else begin
              state_r <= DONE;
            end
          end
        end
        FETCH: begin
          word_r  <= mem_rdata;
          bidx_r  <= 2'd0;
          state_r <= (mem_rdata == 32'd0) ? DONE : EMIT;
        end
        EMIT: begin
          if (advance_s) begin
            if (bidx_r != 2'd3) begin
              bidx_r <= bidx_r + 2'd1;
            end else begin
              ptr_r  <= ptr_r + 32'd1;
              wcnt_r <= wcnt_inc_s;
              // A string that never terminates is cut off at the word limit
              if (wcnt_inc_s == WW'(MAX_WORDS)) begin
                state_r <= DONE;
                err_r   <= 1'b1;
              end else begin
                state_r <= FETCH;
              end
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          err_r   <= 1'b0;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_print_arb.sv
// Directed bench for sys_print_arb: print, backpressure, non-print code,
// word-limit abort and memory-port arbitration including reset mid-print.
module tb_sys_print_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sys;
  logic [31:0] regv, rega, cpu_addr, cpu_wdata;
  logic        cpu_memwrite, cpu_memwrite8;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_memwrite, mem_memwrite8;
  logic        char_valid, char_ready;
  logic [7:0]  char_data;
  logic        cpu_stall, sys_done, sys_err;

  logic [31:0] ram [0:15];
  logic [7:0]  chars [0:63];
  int          nchar = 0;
  int          done_cnt = 0;
  int          wr_count = 0;
  logic [31:0] last_wa = 32'd0;
  logic [31:0] last_wd = 32'd0;

  int n_cmp = 0;
  int n_err = 0;
  int c0, d0, w0;

  sys_print_arb #(.MAX_WORDS(2)) dut (
    .clk(clk), .rst_n(rst_n), .sys(sys), .regv(regv), .rega(rega),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_memwrite(cpu_memwrite), .cpu_memwrite8(cpu_memwrite8),
    .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_memwrite(mem_memwrite), .mem_memwrite8(mem_memwrite8),
    .mem_rdata(mem_rdata), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .cpu_stall(cpu_stall), .sys_done(sys_done),
    .sys_err(sys_err)
  );

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr[3:0]];

  // Sink, completion and write observers
  always @(posedge clk) begin
    if (rst_n && char_valid && char_ready) begin
      chars[nchar % 64] <= char_data;
      nchar <= nchar + 1;
    end
    if (sys_done) done_cnt <= done_cnt + 1;
    if (mem_memwrite) begin
      wr_count <= wr_count + 1;
      last_wa  <= mem_addr;
      last_wd  <= mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 32'd0;
    ram[0] = 32'h0021_6948;
    ram[1] = 32'h0000_0000;
    ram[4] = 32'h4141_4141;
    ram[5] = 32'h4141_4141;
    ram[6] = 32'h4141_4141;
    ram[7] = 32'h0000_0000;
    rst_n = 1'b0; sys = 1'b0; regv = 32'd0; rega = 32'd0;
    cpu_addr = 32'h0000_0055; cpu_wdata = 32'h0000_00AA;
    cpu_memwrite = 1'b1; cpu_memwrite8 = 1'b1; char_ready = 1'b1;

    // Reset state
    tick(); tick(); #1;
    chk("rst_cv", {31'd0, char_valid}, 32'd0);
    chk("rst_done", {31'd0, sys_done}, 32'd0);
    chk("rst_err", {31'd0, sys_err}, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_maddr", mem_addr, 32'h0000_0055);
    chk("rst_mwr", {30'd0, mem_memwrite, mem_memwrite8}, 32'd3);
    cpu_memwrite = 1'b0; cpu_memwrite8 = 1'b0;
    tick(); rst_n = 1'b1;

    // Print "Hi!"
    tick(); sys = 1'b1; regv = 32'd4; rega = 32'h0040_0000; #1;
    chk("hi_acc_stall", {31'd0, cpu_stall}, 32'd0);
    c0 = nchar; d0 = done_cnt;
    tick(); sys = 1'b0; #1;
    chk("hi_fetch_stall", {31'd0, cpu_stall}, 32'd1);
    chk("hi_fetch_addr", mem_addr, 32'h0040_0000);
    chk("hi_fetch_cv", {31'd0, char_valid}, 32'd0);
    tick(); #1;
    chk("hi_b0", {23'd0, char_valid, char_data}, 32'h148);
    tick(); #1;
    chk("hi_b1", {23'd0, char_valid, char_data}, 32'h169);
    tick(); #1;
    chk("hi_b2", {23'd0, char_valid, char_data}, 32'h121);
    tick(); #1;
    chk("hi_b3_cv", {31'd0, char_valid}, 32'd0);
    tick(); #1;
    chk("hi_fetch2_done", {31'd0, sys_done}, 32'd0);
    chk("hi_fetch2_addr", mem_addr, 32'h0040_0001);
    tick(); #1;
    chk("hi_done", {29'd0, sys_done, sys_err, cpu_stall}, 32'b101);
    tick(); #1;
    chk("hi_idle", {30'd0, sys_done, cpu_stall}, 32'd0);
    chk("hi_nchar", nchar - c0, 32'd3);
    chk("hi_chars", {8'd0, chars[c0 % 64], chars[(c0 + 1) % 64], chars[(c0 + 2) % 64]}, 32'h0048_6921);
    chk("hi_ndone", done_cnt - d0, 32'd1);

    // Backpressure on 'i'
    sys = 1'b1; regv = 32'd4; rega = 32'h0040_0000;
    c0 = nchar; d0 = done_cnt;
    tick(); sys = 1'b0;
    tick(); #1;
    chk("bp_b0", {23'd0, char_valid, char_data}, 32'h148);
    for (int i = 0; i < 3; i++) begin
      tick(); char_ready = 1'b0; #1;
      chk("bp_hold", {23'd0, char_valid, char_data}, 32'h169);
    end
    tick(); char_ready = 1'b1; #1;
    chk("bp_release", {23'd0, char_valid, char_data}, 32'h169);
    tick(); #1;
    chk("bp_b2", {23'd0, char_valid, char_data}, 32'h121);
    tick(); tick(); tick(); #1;
    chk("bp_done", {31'd0, sys_done}, 32'd1);
    tick();
    chk("bp_nchar", nchar - c0, 32'd3);
    chk("bp_chars", {8'd0, chars[c0 % 64], chars[(c0 + 1) % 64], chars[(c0 + 2) % 64]}, 32'h0048_6921);

    // Non-print syscall code
    cpu_addr = 32'h0000_1000; sys = 1'b1; regv = 32'd10; c0 = nchar; #1;
    chk("np_acc_addr", mem_addr, 32'h0000_1000);
    tick(); sys = 1'b0; #1;
    chk("np_done", {29'd0, sys_done, sys_err, char_valid}, 32'b100);
    tick(); #1;
    chk("np_idle", {30'd0, sys_done, cpu_stall}, 32'd0);
    chk("np_nchar", nchar - c0, 32'd0);

    // Word-limit abort with MAX_WORDS=2
    sys = 1'b1; regv = 32'd4; rega = 32'h0040_0004; c0 = nchar;
    tick(); sys = 1'b0;
    for (int i = 0; i < 40 && !sys_done; i++) tick();
    #1;
    chk("lim_done_err", {30'd0, sys_done, sys_err}, 32'b11);
    chk("lim_nchar", nchar - c0, 32'd8);
    chk("lim_chars", {chars[c0 % 64], chars[(c0 + 3) % 64], chars[(c0 + 4) % 64], chars[(c0 + 7) % 64]}, 32'h4141_4141);
    tick(); #1;
    chk("lim_err_clr", {30'd0, sys_done, sys_err}, 32'd0);

    // Arbitration: CPU write in the accept cycle, blocked write in EMIT, reset mid-print
    sys = 1'b1; regv = 32'd4; rega = 32'h0040_0000;
    cpu_addr = 32'hFFFF_0004; cpu_wdata = 32'h0000_1234; cpu_memwrite = 1'b1; #1;
    chk("arb_acc_wr", {31'd0, mem_memwrite}, 32'd1);
    chk("arb_acc_addr", mem_addr, 32'hFFFF_0004);
    chk("arb_acc_wdata", mem_wdata, 32'h0000_1234);
    w0 = wr_count; d0 = done_cnt;
    tick(); sys = 1'b0; cpu_memwrite = 1'b0; #1;
    chk("arb_commit_addr", last_wa, 32'hFFFF_0004);
    chk("arb_commit_data", last_wd, 32'h0000_1234);
    tick(); cpu_addr = 32'h0000_0077; cpu_memwrite = 1'b1; cpu_memwrite8 = 1'b1; #1;
    chk("arb_emit_cv", {31'd0, char_valid}, 32'd1);
    chk("arb_emit_wr", {30'd0, mem_memwrite, mem_memwrite8}, 32'd0);
    chk("arb_emit_addr", mem_addr, 32'h0040_0000);
    tick(); #1;
    chk("arb_wr_count", wr_count - w0, 32'd1);
    rst_n = 1'b0; #1;
    chk("arb_rst_pass", {30'd0, mem_memwrite, cpu_stall}, 32'b10);
    chk("arb_rst_cv", {31'd0, char_valid}, 32'd0);
    tick(); rst_n = 1'b1; cpu_memwrite = 1'b0; cpu_memwrite8 = 1'b0; #1;
    chk("arb_after_rst", {29'd0, cpu_stall, sys_done, char_valid}, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("arb_no_done", done_cnt - d0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sys_print_arb.md
SYS_PRINT_ARB -- requirements
Module: sys_print_arb

Interface
REQ-001 SHALL have parameter: MAX_WORDS, default 8192, max words fetched per print request before abort.
REQ-002 SHALL have port: clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: sys  input  1  syscall strobe from the pipeline.
REQ-005 SHALL have port: regv  input  32  syscall code ($v0).
REQ-006 SHALL have port: rega  input  32  string base word address ($a0).
REQ-007 SHALL have port: cpu_addr / cpu_wdata  input  32 each  CPU data-port address and write data.
REQ-008 SHALL have port: cpu_memwrite / cpu_memwrite8  input  1 each  CPU word write and byte write.
REQ-009 SHALL have port: cpu_rdata  output  32  read data returned to the CPU.
REQ-010 SHALL have port: mem_addr / mem_wdata  output  32 each  data-memory address and write data.
REQ-011 SHALL have port: mem_memwrite / mem_memwrite8  output  1 each  data-memory word write and byte write.
REQ-012 SHALL have port: mem_rdata  input  32  data-memory read data, combinational from mem_addr.
REQ-013 SHALL have port: char_valid  output  1  output character valid.
REQ-014 SHALL have port: char_data  output  8  output character.
REQ-015 SHALL have port: char_ready  input  1  character sink accepts.
REQ-016 SHALL have ports: cpu_stall, sys_done, sys_err  output  1 each  CPU hold, completion pulse, limit abort.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, EMIT, DONE; the memory port is owned by the CPU in IDLE and by the engine otherwise.
REQ-018 In IDLE, mem_* SHALL equal the corresponding cpu_* inputs combinationally.
REQ-019 In all other states, mem_addr SHALL equal ptr and mem_memwrite = mem_memwrite8 = 0.
REQ-020 cpu_rdata SHALL equal mem_rdata at all times; cpu_stall SHALL equal (state != IDLE).
REQ-021 IDLE with sys=1 and regv==4: next state FETCH, ptr<=rega, wcnt<=0; the CPU access in the same cycle SHALL still pass through.
REQ-022 IDLE with sys=1 and regv!=4: next state DONE; no memory access and no character emitted.
REQ-023 sys SHALL be ignored outside IDLE.
REQ-024 FETCH: one cycle; word<=mem_rdata and bidx<=0; if mem_rdata==0, next state DONE, else EMIT.
REQ-025 EMIT: byte = word[8*bidx+7 : 8*bidx], emitted in order bidx 0..3 (bits [7:0] first).
REQ-026 EMIT, nonzero byte: char_valid=1, char_data=byte; advance only on a cycle with char_valid&&char_ready; char_data SHALL hold stable while stalled.
REQ-027 EMIT, zero byte: char_valid=0; advance in one cycle.
REQ-028 Advance at bidx<3: bidx+1.
REQ-029 Advance at bidx==3: ptr<=ptr+1 (wraps modulo 2^32), wcnt<=wcnt+1; if wcnt+1==MAX_WORDS, next state DONE with err flag set, else FETCH.
REQ-030 DONE: one cycle; sys_done=1 and sys_err=err flag; then IDLE with err cleared.
REQ-031 wcnt SHALL be at least clog2(MAX_WORDS)+1 bits wide.
REQ-032 Minimum latency for an empty string SHALL be: sys cycle, FETCH, DONE (sys_done 2 cycles after the sys edge).

Reset
REQ-033 rst_n=0 sampled at a clock edge SHALL force state=IDLE, ptr=0, wcnt=0, word=0, bidx=0, err=0.
REQ-034 During reset, char_valid=0, sys_done=0, sys_err=0, cpu_stall=0, and mem_* follow cpu_*.
REQ-035 Reset mid-print SHALL abort without emitting a sys_done pulse.

Verification
REQ-036 Print "Hi!": ram[0x400000]=0x00216948, ram[0x400001]=0; sys=1, regv=4, rega=0x400000; char_ready=1 -> chars 'H','i','!', then sys_done exactly 1 cycle; zero byte not emitted; cpu_stall high from FETCH through DONE.
REQ-037 Backpressure: same setup with char_ready low for 3 cycles on 'i' -> char_valid and char_data=0x69 held for 3 cycles; no duplicated or lost char.
REQ-038 Non-print code: sys=1, regv=10 -> sys_done pulse 1 cycle later; no char_valid; mem_addr never equals ptr.
REQ-039 Limit abort: MAX_WORDS=2, three words 0x41414141 then 0 -> 8 'A' chars, then sys_done=1 with sys_err=1.
REQ-040 Arbitration: CPU word write 0x1234 to 0xFFFF0004 in the sys accept cycle commits; a CPU write asserted during EMIT does not reach mem_memwrite; rst_n=0 during EMIT -> IDLE next cycle, no sys_done.
